// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage.
// Access-size encodings and the bus FSM state enum.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper: store enables/replication, load extract/extend.
// In: size, addr lo bits, unsigned, wdata, rdata. Out: be, wrep, ldata, misal.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] ldata,
  output logic        misal
);

  logic       is_byte;
  logic       is_half;
  logic [7:0]  blane;
  logic [15:0] hlane;

  assign is_byte = (size == SZ_BYTE);
  assign is_half = (size == SZ_HALF);

  always_comb begin
    blane = rdata[7:0];
    unique case (lo)
      2'd0: blane = rdata[7:0];
      2'd1: blane = rdata[15:8];
      2'd2: blane = rdata[23:16];
      2'd3: blane = rdata[31:24];
      default: blane = rdata[7:0];
    endcase
    hlane = lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Size 11 falls into the word arm.
  always_comb begin
    be    = 4'b1111;
    wrep  = wdata;
    ldata = rdata;
    misal = 1'b0;
    unique case (1'b1)
      is_byte: begin
        be    = 4'b0001 << lo;
        wrep  = {4{wdata[7:0]}};
        ldata = {{24{blane[7] & ~uns}}, blane};
      end
      is_half: begin
        be    = lo[1] ? 4'b1100 : 4'b0011;
        wrep  = {2{wdata[15:0]}};
        ldata = {{16{hlane[15] & ~uns}}, hlane};
        misal = lo[0];
      end
      default: begin
        misal = |lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: one load/store per instruction over a req/ack bus.
// In: EX/MEM access fields, wb_flush, bus ack/rdata. Out: bus req, mem_data, stall, addr errors.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_mem_mem_read,
  input  logic              ex_mem_mem_write,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  input  logic              wb_flush,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_stall,
  output logic              mem_adel,
  output logic              mem_ades,
  output logic [ADDR_W-1:0] mem_badvaddr
);

  mau_state_e        state_q, state_d;
  logic              kill_q, kill_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;

  logic        is_idle;
  logic [1:0]  al_size;
  logic [1:0]  al_lo;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wrep;
  logic [31:0] al_ldata;
  logic        al_misal;
  logic        acc_valid;
  logic        killed;

  assign is_idle = (state_q == ST_IDLE);

  // IDLE decodes the incoming access; REQ extracts with latched fields.
  assign al_size = is_idle ? ex_mem_size : size_q;
  assign al_lo   = is_idle ? ex_mem_addr[1:0] : addr_q[1:0];
  assign al_uns  = is_idle ? ex_mem_unsigned : uns_q;

  mem_lane_align u_align (
    .size  (al_size),
    .lo    (al_lo),
    .uns   (al_uns),
    .wdata (ex_mem_wdata),
    .rdata (bus_rdata),
    .be    (al_be),
    .wrep  (al_wrep),
    .ldata (al_ldata),
    .misal (al_misal)
  );

  assign acc_valid = (ex_mem_mem_read | ex_mem_mem_write)
                   & ~al_misal & ~wb_flush;
  assign killed    = kill_q | wb_flush;

  assign mem_adel = is_idle & ex_mem_mem_read & al_misal & ~wb_flush;
  assign mem_ades = is_idle & ex_mem_mem_write & al_misal & ~wb_flush;
  assign mem_badvaddr = (mem_adel | mem_ades) ? ex_mem_addr : '0;

  assign mem_stall = (is_idle & acc_valid) | (state_q == ST_REQ);

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    mdata_d = mdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc_valid) begin
          state_d = ST_REQ;
          kill_d  = 1'b0;
          req_d   = 1'b1;
          we_d    = ex_mem_mem_write;
          addr_d  = ex_mem_addr;
          be_d    = al_be;
          wdata_d = ex_mem_mem_write ? al_wrep : '0;
          size_d  = ex_mem_size;
          uns_d   = ex_mem_unsigned;
        end
      end
      ST_REQ: begin
        // The bus cycle cannot be aborted; a flush only marks it killed.
        kill_d = killed;
        if (bus_ack) begin
          req_d  = 1'b0;
          kill_d = 1'b0;
          if (~we_q & ~killed) begin
            mdata_d = al_ldata;
          end
          state_d = killed ? ST_IDLE : ST_DONE;
        end
      end
      // One dead cycle so the still-held EX/MEM access is not reissued.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      mdata_q <= mdata_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign mem_data  = mdata_q;

endmodule
